// File: rtl/id_stage.sv
// Decode stage: IF/ID pipeline register, 8x8 register file, operand decode and load-use stall.
// Optional build macro WB_BYPASS_EN: same-cycle write-back data is forwarded onto A_out/B_out.
module id_stage #(
    parameter int         NREGS   = 8,
    parameter logic [3:0] OP_LOAD = 4'hA,
    parameter logic [3:0] OP_ADDI = 4'h9
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] instr_in,
    input  logic        instr_valid,
    input  logic        flush,
    input  logic [3:0]  ex_opcode,
    input  logic [2:0]  ex_rd,
    input  logic        wb_en,
    input  logic [2:0]  wb_rd,
    input  logic [7:0]  wb_data,
    output logic [3:0]  opcode_out,
    output logic [7:0]  A_out,
    output logic [7:0]  B_out,
    output logic [2:0]  rd_out,
    output logic        stall
);

    logic [15:0] ir_q, ir_d;
    logic [7:0]  regs_q [0:NREGS-1];

    logic [3:0]  op;
    logic [2:0]  rd, rs1, rs2;
    logic [5:0]  imm6;
    logic        is_nop, uses_imm;
    logic [7:0]  rs1_val, rs2_val;

    always_comb begin
        op       = ir_q[15:12];
        rd       = ir_q[11:9];
        rs1      = ir_q[8:6];
        rs2      = ir_q[5:3];
        imm6     = ir_q[5:0];
        is_nop   = (op == 4'h0);
        uses_imm = (op == OP_ADDI) || (op == OP_LOAD);

        // R0 is hard-wired to zero regardless of what the array holds.
        rs1_val = (rs1 == 3'd0) ? 8'h00 : regs_q[rs1];
        rs2_val = (rs2 == 3'd0) ? 8'h00 : regs_q[rs2];
`ifdef WB_BYPASS_EN
        if (wb_en && (wb_rd != 3'd0) && (wb_rd == rs1)) rs1_val = wb_data;
        if (wb_en && (wb_rd != 3'd0) && (wb_rd == rs2)) rs2_val = wb_data;
`endif

        opcode_out = op;
        rd_out     = rd;
        A_out      = rs1_val;
        B_out      = uses_imm ? {2'b00, imm6} : rs2_val;
        if (is_nop) begin
            opcode_out = 4'h0;
            rd_out     = 3'd0;
            A_out      = 8'h00;
            B_out      = 8'h00;
        end

        // Load in EX whose result the decoding instruction needs; rs2 only matters when it is a register read.
        stall = (ex_opcode == OP_LOAD) && (ex_rd != 3'd0) && !is_nop && !flush &&
                ((ex_rd == rs1) || ((ex_rd == rs2) && !uses_imm));
    end

    always_comb begin
        if (flush)            ir_d = 16'h0000;
        else if (stall)       ir_d = ir_q;
        else if (instr_valid) ir_d = instr_in;
        else                  ir_d = 16'h0000;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ir_q <= 16'h0000;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= 8'h00;
        end else begin
            ir_q <= ir_d;
            for (int i = 1; i < NREGS; i++) begin
                if (wb_en && (wb_rd == 3'(i))) regs_q[i] <= wb_data;
            end
        end
    end

endmodule
